mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access controller of the 5-stage MIPS datapath, between the EX/MEM pipeline buffer and the MEM/WB buffer. It turns the load/store control of the instruction in MEM into a request/acknowledge transaction on the data-memory bus. It handles byte/half/word sizing, lane steering and sign/zero extension, and stalls the pipeline until the access completes. Its `dataMem_o` drives the MEM/WB buffer's `dataMem_i`.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent in BUSY waiting for `memAck_i`. 0 disables the timeout.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  instruction in MEM stage is valid.
- `memRead_i`  in  1  load.
- `memWrite_i`  in  1  store; takes priority if `memRead_i` is also 1.
- `memSize_i`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `memUnsigned_i`  in  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0.
- `aluResult_i`  in  32  effective byte address.
- `writeData_i`  in  32  store data, right-aligned.
- `memReq_o`  out  1  bus request, registered.
- `memWe_o`  out  1  bus write enable.
- `memAddr_o`  out  32  word address, `{addr[31:2],2'b00}`.
- `memBe_o`  out  4  byte enables.
- `memWdata_o`  out  32  lane-replicated store data.
- `memAck_i`  in  1  completion strobe; `memRdata_i` is valid in the same cycle.
- `memRdata_i`  in  32  read word.
- `dataMem_o`  out  32  extended load result, registered.
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB.
- `misaligned_o`  out  1  one-cycle pulse: misaligned access rejected.
- `busErr_o`  out  1  one-cycle pulse: timeout abort.

## Operation
- **Access condition.** `acc = valid_i & (memRead_i | memWrite_i)`.
- **Alignment.** Misaligned when half with `addr[0]=1`, or word with `addr[1:0]≠0`.
- **IDLE state.**
  - `acc` and aligned: latch addr, we, be, wdata, size, unsigned, lane. Set `memReq_o`, go to BUSY.
  - `acc` and misaligned: no request, no stall. Pulse `misaligned_o` next cycle. `dataMem_o`←0. Stay in IDLE.
  - No access: stay in IDLE; `dataMem_o` holds.
- **BUSY state.** `memReq_o`, `memWe_o`, `memAddr_o`, `memBe_o` and `memWdata_o` are held stable from the latched values.
  - `memAck_i=1`: drop `memReq_o`. Load: `dataMem_o`←extended data. Store: `dataMem_o` holds. Go to DONE.
  - Timeout counter reaches `TIMEOUT` with no ack: drop `memReq_o`, `dataMem_o`←0, pulse `busErr_o`, go to DONE.
- **DONE state.** `stall_o=0`, so MEM/WB samples `dataMem_o` at the end of this cycle. Always return to IDLE.
- **stall_o (combinational).** `(IDLE & acc & aligned) | BUSY`.
- **Store steering.**
  - Byte: `be=1<<addr[1:0]`, `wdata={4{wd[7:0]}}`.
  - Half: `be=addr[1]?1100:0011`, `wdata={2{wd[15:0]}}`.
  - Word: `be=1111`, `wdata=wd`.
- **Load steering.**
  - Byte: `rdata[8*addr[1:0]+:8]`.
  - Half: `addr[1]?rdata[31:16]:rdata[15:0]`.
  - Result is sign- or zero-extended per `memUnsigned_i`.
- **Spurious ack.** `memAck_i` outside BUSY is ignored.
- **Counter.** Width `$clog2(TIMEOUT+1)`. Cleared on entry to BUSY, increments each BUSY cycle without ack. Ack in the same cycle the counter hits `TIMEOUT`: ack wins.
- **Reset.** `rst_ni` low at any time, including mid-transaction, immediately forces:
  - state IDLE, counter 0;
  - `memReq_o=0`, `memWe_o=0`, `memAddr_o=0`, `memBe_o=0`, `memWdata_o=0`;
  - `dataMem_o=0`, `misaligned_o=0`, `busErr_o=0`.

## Timing
- Aligned access presented in cycle N: `stall_o=1` in N, `memReq_o=1` from N+1.
- Ack in cycle M ≥ N+1: DONE in M+1 with `stall_o=0`. Minimum occupancy 3 cycles, of which 2 are stall.
- Back-to-back accesses: the next instruction's IDLE cycle follows DONE.
- Misaligned or non-memory instruction: 1 cycle, zero stall.
- `misaligned_o` and `busErr_o` are each exactly 1 cycle wide.

## Test plan
- Reset, then `lw` at 0x100, ack at N+1 with rdata 0xDEADBEEF:
  - `memReq_o` high in N+1 only, `memAddr_o`=0x100, `memWe_o`=0;
  - `stall_o` high in N and N+1;
  - `dataMem_o`=0xDEADBEEF in N+2.
- `lb` at 0x103 with rdata 0x80000000 → `dataMem_o`=0xFFFFFF80. `lbu` at 0x103 → 0x00000080. `lhu` at 0x102 with rdata 0xBEEF0000 → 0x0000BEEF.
- `sh` of 0x1234ABCD at 0x206 → `memBe_o`=1100, `memWdata_o`=0xABCDABCD, `memWe_o`=1. Ack delayed 5 cycles → `stall_o` high for 6 cycles.
- `lw` at 0x101 → no `memReq_o`, `stall_o`=0, `misaligned_o` pulses 1 cycle, `dataMem_o`=0.
- With `TIMEOUT`=4 and ack never asserted → `busErr_o` pulses after 4 BUSY cycles, `memReq_o` drops, `dataMem_o`=0, next cycle IDLE. Ack in the 4th BUSY cycle → normal completion, no `busErr_o`.
- `rst_ni` low during BUSY → `memReq_o` falls asynchronously, state IDLE. A later ack is ignored and `dataMem_o` stays 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: turns load/store control into a
// req/ack data-memory transaction with sizing, steering and extension.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        memRead_i,
    input  logic        memWrite_i,
    input  logic [1:0]  memSize_i,
    input  logic        memUnsigned_i,
    input  logic [31:0] aluResult_i,
    input  logic [31:0] writeData_i,
    output logic        memReq_o,
    output logic        memWe_o,
    output logic [31:0] memAddr_o,
    output logic [3:0]  memBe_o,
    output logic [31:0] memWdata_o,
    input  logic        memAck_i,
    input  logic [31:0] memRdata_i,
    output logic [31:0] dataMem_o,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        busErr_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic [1:0]    lane_q;
    logic          uns_q;

    logic        acc, is_byte, is_half, is_word;
    logic        misal, start, tmo;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_c;

    assign acc     = valid_i & (memRead_i | memWrite_i);
    assign is_byte = (memSize_i == 2'b00);
    assign is_half = (memSize_i == 2'b01);
    assign is_word = memSize_i[1];
    assign misal   = (is_half & aluResult_i[0])
                   | (is_word & (|aluResult_i[1:0]));
    assign start   = (state == IDLE) & acc & ~misal;
    assign stall_o = start | (state == BUSY);

    // A zero TIMEOUT leaves the wait unbounded.
    assign tmo = (TIMEOUT != 0) & (state == BUSY) & ~memAck_i
               & (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = writeData_i;
        unique case (1'b1)
            is_byte: begin
                be_c    = 4'b0001 << aluResult_i[1:0];
                wdata_c = {4{writeData_i[7:0]}};
            end
            is_half: begin
                be_c    = aluResult_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{writeData_i[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = writeData_i;
            end
        endcase
    end

    always_comb begin
        ld_byte = memRdata_i[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? memRdata_i[31:16] : memRdata_i[15:0];
        load_c  = memRdata_i;
        unique case (1'b1)
            (size_q == 2'b00):
                load_c = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            (size_q == 2'b01):
                load_c = {{16{~uns_q & ld_half[15]}}, ld_half};
            default:
                load_c = memRdata_i;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = BUSY;
            BUSY:    if (memAck_i || tmo) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            size_q       <= '0;
            lane_q       <= '0;
            uns_q        <= 1'b0;
            memReq_o     <= 1'b0;
            memWe_o      <= 1'b0;
            memAddr_o    <= '0;
            memBe_o      <= '0;
            memWdata_o   <= '0;
            dataMem_o    <= '0;
            misaligned_o <= 1'b0;
            busErr_o     <= 1'b0;
        end else begin
            state        <= state_n;
            misaligned_o <= 1'b0;
            busErr_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        memReq_o   <= 1'b1;
                        memWe_o    <= memWrite_i;
                        memAddr_o  <= {aluResult_i[31:2], 2'b00};
                        memBe_o    <= be_c;
                        memWdata_o <= wdata_c;
                        size_q     <= memSize_i;
                        lane_q     <= aluResult_i[1:0];
                        uns_q      <= memUnsigned_i;
                        cnt        <= '0;
                    end else if (acc) begin
                        misaligned_o <= 1'b1;
                        dataMem_o    <= '0;
                    end
                end
                BUSY: begin
                    if (memAck_i) begin
                        memReq_o <= 1'b0;
                        if (!memWe_o) dataMem_o <= load_c;
                    end else if (tmo) begin
                        memReq_o  <= 1'b0;
                        dataMem_o <= '0;
                        busErr_o  <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
